// File: rtl/frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : frame_sequencer
// Purpose  : Per-frame scheduler between the VGA timing and the game-object
//            update logic. On each start of vertical blank it decides whether
//            the frame just drawn ended in failure (collision / out-of-bound
//            seen during active video). If it did not, it walks a one-hot
//            update request across the clients in index order, one at a time,
//            over a req/done handshake. Object state therefore only changes
//            while nothing is being drawn.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CLIENTS     number of update clients, index 0 served first
//   TIMEOUT     maximum clk cycles a request waits for done
//   CNT_W       frame counter width
// Ports
//   clk          in   system clock
//   rstn         in   asynchronous active-low reset
//   vblank       in   vertical blank, asynchronous to clk
//   enable       in   game running
//   hit          in   per-pixel collision, meaningful during active video
//   oob          in   bird out of bound
//   no_die       in   debug switch, suppresses failed
//   upd_req      out  one-hot update request (or zero)
//   upd_done     in   per-client completion
//   frame_tick   out  one-cycle pulse after all clients were served
//   failed       out  one-cycle pulse when the frame ends in failure
//   busy         out  sequencer not idle
//   overrun      out  sticky: vblank start seen while busy
//   timeout_err  out  sticky per-client timeout flags
//   frame_count  out  number of completed sequences (wraps)
// ============================================================================
module frame_sequencer #(
    parameter int CLIENTS = 3,
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               vblank,
    input  logic               enable,
    input  logic               hit,
    input  logic               oob,
    input  logic               no_die,
    output logic [CLIENTS-1:0] upd_req,
    input  logic [CLIENTS-1:0] upd_done,
    output logic               frame_tick,
    output logic               failed,
    output logic               busy,
    output logic               overrun,
    output logic [CLIENTS-1:0] timeout_err,
    output logic [CNT_W-1:0]   frame_count
);

    localparam int c_WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_EVAL = 2'd1;
    localparam logic [1:0] c_S_REQ  = 2'd2;
    localparam logic [1:0] c_S_TICK = 2'd3;

    // ------------------------------------------------------------------------
    // vblank synchroniser and rise detector
    // ------------------------------------------------------------------------
    logic       r_vb_sync1;
    logic       r_vb_sync2;
    logic       r_vb_prev;
    logic [1:0] r_vb_fill;
    logic       w_vb_valid;
    logic       w_vb_rise;

    // r_vb_fill counts the edges since reset until sync1, sync2 and prev all
    // hold real samples. Without it a vblank that is already high when reset
    // releases would look like a 0->1 edge while the pipeline fills.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vb_sync1 <= 1'b0;
            r_vb_sync2 <= 1'b0;
            r_vb_prev  <= 1'b0;
            r_vb_fill  <= 2'd0;
        end else begin
            r_vb_sync1 <= vblank;
            r_vb_sync2 <= r_vb_sync1;
            r_vb_prev  <= r_vb_sync2;
            if (r_vb_fill != 2'd3) begin
                r_vb_fill <= r_vb_fill + 2'd1;
            end
        end
    end

    assign w_vb_valid = (r_vb_fill == 2'd3);
    assign w_vb_rise  = r_vb_sync2 & ~r_vb_prev & w_vb_valid;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                r_hit_seen;
    logic [CLIENTS-1:0]  r_upd_req;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                r_frame_tick;
    logic                r_failed;
    logic                r_overrun;
    logic [CLIENTS-1:0]  r_timeout_err;
    logic [CNT_W-1:0]    r_frame_count;

    // Next values produced by the output process
    logic [CLIENTS-1:0]  w_req_nxt;
    logic [c_WAIT_W-1:0] w_cnt_nxt;
    logic [CLIENTS-1:0]  w_terr_nxt;
    logic [CNT_W-1:0]    w_count_nxt;
    logic                w_tick_nxt;
    logic                w_failed_nxt;
    logic                w_hit_clr;

    logic w_frame_fail;
    logic w_done_sel;
    logic w_timeout;
    logic w_advance;
    logic w_last;

    assign w_frame_fail = r_hit_seen & ~no_die;
    // Only the done bit of the currently requested client matters; masking
    // with the one-hot request discards every other client's done line.
    assign w_done_sel   = |(upd_done & r_upd_req);
    assign w_timeout    = (r_wait_cnt == c_WAIT_LAST);
    assign w_advance    = w_done_sel | w_timeout;
    assign w_last       = r_upd_req[CLIENTS-1];

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_vb_rise && enable) begin
                    w_state_nxt = c_S_EVAL;
                end
            end
            c_S_EVAL: begin
                w_state_nxt = w_frame_fail ? c_S_IDLE : c_S_REQ;
            end
            c_S_REQ: begin
                if (w_advance && w_last) begin
                    w_state_nxt = c_S_TICK;
                end
            end
            c_S_TICK: begin
                w_state_nxt = c_S_IDLE;
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output logic (next values of the registered outputs)
    // ------------------------------------------------------------------------
    always_comb begin
        w_req_nxt    = r_upd_req;
        w_cnt_nxt    = r_wait_cnt;
        w_terr_nxt   = r_timeout_err;
        w_count_nxt  = r_frame_count;
        w_tick_nxt   = 1'b0;
        w_failed_nxt = 1'b0;
        w_hit_clr    = 1'b0;
        case (r_state)
            c_S_EVAL: begin
                w_hit_clr = 1'b1;
                if (w_frame_fail) begin
                    w_failed_nxt = 1'b1;
                end else begin
                    w_req_nxt = CLIENTS'(1);
                    w_cnt_nxt = '0;
                end
            end
            c_S_REQ: begin
                if (w_advance) begin
                    // A timeout flags the client currently holding the request.
                    if (w_timeout && !w_done_sel) begin
                        w_terr_nxt = r_timeout_err | r_upd_req;
                    end
                    if (w_last) begin
                        w_req_nxt = '0;
                    end else begin
                        w_req_nxt = r_upd_req << 1;
                        w_cnt_nxt = '0;
                    end
                end else begin
                    w_cnt_nxt = r_wait_cnt + 1'b1;
                end
            end
            c_S_TICK: begin
                w_tick_nxt  = 1'b1;
                w_count_nxt = r_frame_count + 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output / datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_upd_req     <= '0;
            r_wait_cnt    <= '0;
            r_timeout_err <= '0;
            r_frame_count <= '0;
            r_frame_tick  <= 1'b0;
            r_failed      <= 1'b0;
        end else begin
            r_upd_req     <= w_req_nxt;
            r_wait_cnt    <= w_cnt_nxt;
            r_timeout_err <= w_terr_nxt;
            r_frame_count <= w_count_nxt;
            r_frame_tick  <= w_tick_nxt;
            r_failed      <= w_failed_nxt;
        end
    end

    // Hits only count during active video of a running game; anything seen
    // while blanking or while the game is stopped is discarded.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hit_seen <= 1'b0;
        end else if (!enable || w_hit_clr) begin
            r_hit_seen <= 1'b0;
        end else if ((hit || oob) && !r_vb_sync2) begin
            r_hit_seen <= 1'b1;
        end
    end

    // A vblank start during a sequence is dropped; the flag records it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_overrun <= 1'b0;
        end else if (w_vb_rise && (r_state != c_S_IDLE)) begin
            r_overrun <= 1'b1;
        end
    end

    assign upd_req     = r_upd_req;
    assign frame_tick  = r_frame_tick;
    assign failed      = r_failed;
    assign busy        = (r_state != c_S_IDLE);
    assign overrun     = r_overrun;
    assign timeout_err = r_timeout_err;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_sequencer
// Purpose  : Self-checking bench for frame_sequencer. Each frame is an active
//            video period followed by a vblank rise; the expected request
//            schedule, pulses and counters are computed from the frame rules
//            (client latencies, timeout, hit/enable/no_die) and compared
//            cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_sequencer;

    localparam int CLIENTS = 3;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 3;
    localparam int NEVER   = 1000;

    logic               clk = 1'b0;
    logic               rstn;
    logic               vblank;
    logic               enable;
    logic               hit;
    logic               oob;
    logic               no_die;
    logic [CLIENTS-1:0] upd_req;
    logic [CLIENTS-1:0] upd_done;
    logic               frame_tick;
    logic               failed;
    logic               busy;
    logic               overrun;
    logic [CLIENTS-1:0] timeout_err;
    logic [CNT_W-1:0]   frame_count;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state
    int                 exp_count = 0;
    logic [CLIENTS-1:0] exp_terr  = '0;
    logic               exp_ovr   = 1'b0;

    // Client models: done after lat[i] cycles of seeing req; unselected
    // clients drive random noise on their done line.
    int                 lat [CLIENTS];
    int                 hc  [CLIENTS];
    logic [CLIENTS-1:0] noise = '0;

    always #5 clk = ~clk;

    frame_sequencer #(
        .CLIENTS (CLIENTS),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .vblank      (vblank),
        .enable      (enable),
        .hit         (hit),
        .oob         (oob),
        .no_die      (no_die),
        .upd_req     (upd_req),
        .upd_done    (upd_done),
        .frame_tick  (frame_tick),
        .failed      (failed),
        .busy        (busy),
        .overrun     (overrun),
        .timeout_err (timeout_err),
        .frame_count (frame_count)
    );

    initial begin
        for (int i = 0; i < CLIENTS; i++) begin
            lat[i] = 0;
            hc[i]  = 0;
        end
    end

    always @(posedge clk) begin
        noise <= CLIENTS'($urandom);
        for (int i = 0; i < CLIENTS; i++) begin
            hc[i] <= upd_req[i] ? hc[i] + 1 : 0;
        end
    end

    always_comb begin
        upd_done = '0;
        for (int i = 0; i < CLIENTS; i++) begin
            upd_done[i] = upd_req[i] ? (hc[i] >= lat[i]) : noise[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_req"},   32'(upd_req),     32'd0);
        chk({tag, "_tick"},  32'(frame_tick),  32'd0);
        chk({tag, "_fail"},  32'(failed),      32'd0);
        chk({tag, "_busy"},  32'(busy),        32'd0);
        chk({tag, "_ovr"},   32'(overrun),     32'd0);
        chk({tag, "_terr"},  32'(timeout_err), 32'd0);
        chk({tag, "_count"}, 32'(frame_count), 32'd0);
    endtask

    // mode: 0 random, 1 client 1 never answers, 2 overrun, 3 reset while req[1]
    task automatic run_frame(input bit en, input bit want_hit, input bit nd, input int mode);
        int  s [CLIENTS];
        int  d [CLIENTS];
        int  e_end;
        int  t_last;
        bit  any_hit;
        bit  exp_fail;
        bit  seq;
        bit  stop;
        logic [CLIENTS-1:0] er;

        // Active video
        vblank = 1'b0;
        enable = en;
        no_die = nd;
        hit    = 1'b0;
        oob    = 1'b0;
        for (int i = 0; i < CLIENTS; i++) begin
            lat[i] = ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(0, 5));
        end
        if (mode == 1) lat[1] = NEVER;
        if (mode == 2) lat[0] = NEVER;
        if (mode == 3) lat[0] = 1;
        any_hit = 1'b0;
        repeat (3) step();
        for (int c = 0; c < 8; c++) begin
            if (want_hit && c == 3) begin
                if ($urandom_range(0, 1) == 1) hit = 1'b1;
                else                           oob = 1'b1;
                any_hit = en;
            end else begin
                hit = 1'b0;
                oob = 1'b0;
            end
            step();
        end
        hit = 1'b0;
        oob = 1'b0;
        repeat (3) step();

        // Expected schedule relative to edge k (sample index t = after edge k+t)
        exp_fail = en && any_hit && !nd;
        seq      = en && !exp_fail;
        s[0] = 3;
        for (int i = 0; i < CLIENTS; i++) begin
            d[i] = (lat[i] >= TIMEOUT) ? TIMEOUT : lat[i] + 1;
            if (i > 0) s[i] = s[i-1] + d[i-1];
        end
        e_end  = s[CLIENTS-1] + d[CLIENTS-1];
        t_last = seq ? e_end + 3 : 6;
        stop   = 1'b0;

        vblank = 1'b1;
        for (int t = 0; t <= t_last && !stop; t++) begin
            step();
            er = '0;
            for (int i = 0; i < CLIENTS; i++) begin
                if (seq && t >= s[i] && t < s[i] + d[i]) er[i] = 1'b1;
            end
            if (seq && t == e_end + 1) exp_count = (exp_count + 1) % (1 << CNT_W);
            if (mode == 2 && t == 12) exp_ovr = 1'b1;
            chk("req",   32'(upd_req),     32'(er));
            chk("tick",  32'(frame_tick),  32'(seq && t == e_end + 1));
            chk("fail",  32'(failed),      32'(exp_fail && t == 3));
            chk("busy",  32'(busy),        32'(en && t >= 2 && t <= (seq ? e_end : 2)));
            chk("count", 32'(frame_count), 32'(exp_count));
            chk("ovr",   32'(overrun),     32'(exp_ovr));

            // Stimulus for the next cycle
            hit = (mode != 2 && t >= 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
            oob = (mode != 2 && t >= 1) ? ($urandom_range(0, 5) == 0) : 1'b0;
            if (t == 3 && seq && $urandom_range(0, 1) == 1) enable = 1'b0;
            if (mode == 2 && t == 5) vblank = 1'b0;
            if (mode == 2 && t == 9) vblank = 1'b1;
            if (mode == 3 && t == s[1]) begin
                rstn = 1'b0;
                #1;
                chk_reset_values("midreset");
                exp_count = 0;
                exp_terr  = '0;
                exp_ovr   = 1'b0;
                hit       = 1'b0;
                oob       = 1'b0;
                vblank    = 1'b0;
                repeat (2) step();
                rstn = 1'b1;
                repeat (5) step();
                stop = 1'b1;
            end
        end
        hit = 1'b0;
        oob = 1'b0;

        if (!stop) begin
            if (seq) begin
                for (int i = 0; i < CLIENTS; i++) begin
                    if (lat[i] >= TIMEOUT) exp_terr[i] = 1'b1;
                end
            end
            chk("terr",     32'(timeout_err), 32'(exp_terr));
            chk("ovr_end",  32'(overrun),     32'(exp_ovr));
            chk("idle_end", 32'(busy),        32'd0);
        end
    endtask

    initial begin
        rstn   = 1'b0;
        vblank = 1'b1;
        enable = 1'b1;
        hit    = 1'b0;
        oob    = 1'b0;
        no_die = 1'b0;
        repeat (3) step();
        chk_reset_values("reset");

        // vblank already high at reset release must not start a sequence
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("norise_busy", 32'(busy),    32'd0);
            chk("norise_req",  32'(upd_req), 32'd0);
        end

        run_frame(1'b1, 1'b0, 1'b0, 0);   // clean frame
        run_frame(1'b1, 1'b1, 1'b0, 0);   // collision -> failed
        run_frame(1'b1, 1'b1, 1'b1, 0);   // collision with no_die
        run_frame(1'b1, 1'b0, 1'b0, 1);   // client 1 timeout
        run_frame(1'b0, 1'b1, 1'b0, 0);   // game stopped
        run_frame(1'b1, 1'b0, 1'b0, 2);   // overrun
        run_frame(1'b1, 1'b0, 1'b0, 3);   // reset during req[1]
        run_frame(1'b1, 1'b0, 1'b0, 0);   // restart after reset

        for (int f = 0; f < 24; f++) begin
            run_frame($urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
                      $urandom_range(0, 3) == 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
